dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_addr_map.sv | 50 +++++
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// segment defaults, RAM word-address width and the round-robin pick helper.
package dmem_arbiter_pkg;

  localparam logic [31:0] GLOBAL_BASE_DEF = 32'h1001_0000;
  localparam logic [31:0] STACK_BASE_DEF  = 32'h7FFF_EFFC;
  localparam logic [31:0] SEG_BYTES_DEF   = 32'd4096;
  localparam int          PADDR_W_DEF     = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    RESP_ERR = 2'd3
  } state_t;

  // On a conflict the port that did not win last time is chosen.
  function automatic logic pick_port(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      return ~last;
    end
    return r1;
  endfunction

endpackage

// File: rtl/dmem_addr_map.sv
// Combinational MIPS virtual data address -> RAM word address map.
// Define DMEM_ARB_ALIGN_CHECK_EN to reject in-range addresses with a[1:0] != 0.
module dmem_addr_map
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] GLOBAL_BASE = GLOBAL_BASE_DEF,
  parameter logic [31:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [31:0] SEG_BYTES   = SEG_BYTES_DEF,
  parameter int          PADDR_W     = PADDR_W_DEF
) (
  input  logic [31:0]        vaddr,
  output logic [PADDR_W-1:0] paddr,
  output logic               invalid
);

  logic [31:0] g_off;
  logic [31:0] s_off;
  logic        g_hit;
  logic        s_hit;
  logic        misaligned;

  // Unsigned wrap makes addresses below a base land far outside the segment.
  assign g_off = vaddr - GLOBAL_BASE;
  assign s_off = vaddr - STACK_BASE;
  assign g_hit = (g_off < SEG_BYTES);
  assign s_hit = (s_off < SEG_BYTES);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misaligned = (vaddr[1:0] != 2'b00);
  logic unused_bits;
  assign unused_bits = ^{g_off[31:PADDR_W+1], s_off[31:PADDR_W+1], g_off[1:0], s_off[1:0]};
`else
  assign misaligned = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{g_off[31:PADDR_W+1], s_off[31:PADDR_W+1], g_off[1:0], s_off[1:0], vaddr[1:0]};
`endif

  always_comb begin
    paddr   = '0;
    invalid = 1'b1;
    if (g_hit) begin
      paddr   = {1'b0, g_off[PADDR_W:2]};
      invalid = misaligned;
    end else if (s_hit) begin
      paddr   = {1'b1, s_off[PADDR_W:2]};
      invalid = misaligned;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data RAM.
// Optional alignment checking is enabled with DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] GLOBAL_BASE = GLOBAL_BASE_DEF,
  parameter logic [31:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [31:0] SEG_BYTES   = SEG_BYTES_DEF,
  parameter int          PADDR_W     = PADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               p0_req,
  input  logic               p0_we,
  input  logic [31:0]        p0_addr,
  input  logic [31:0]        p0_wdata,
  output logic               p0_ack,
  output logic               p0_err,
  output logic [31:0]        p0_rdata,

  input  logic               p1_req,
  input  logic               p1_we,
  input  logic [31:0]        p1_addr,
  input  logic [31:0]        p1_wdata,
  output logic               p1_ack,
  output logic               p1_err,
  output logic [31:0]        p1_rdata,

  output logic               mem_en,
  output logic               mem_we,
  output logic [PADDR_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  state_t state_reg;
  logic   last_grant_reg;
  logic   port_reg;
  logic   we_reg;

  logic               r0;
  logic               r1;
  logic               req_any;
  logic               sel_port;
  logic               sel_we;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [PADDR_W-1:0] map_paddr;
  logic               map_invalid;

  // A request seen during its own ack cycle is the one just served, not a new one.
  assign r0        = p0_req & ~p0_ack;
  assign r1        = p1_req & ~p1_ack;
  assign req_any   = r0 | r1;
  assign sel_port  = pick_port(r0, r1, last_grant_reg);
  assign sel_we    = sel_port ? p1_we    : p0_we;
  assign sel_addr  = sel_port ? p1_addr  : p0_addr;
  assign sel_wdata = sel_port ? p1_wdata : p0_wdata;

  dmem_addr_map #(
    .GLOBAL_BASE (GLOBAL_BASE),
    .STACK_BASE  (STACK_BASE),
    .SEG_BYTES   (SEG_BYTES),
    .PADDR_W     (PADDR_W)
  ) u_addr_map (
    .vaddr   (sel_addr),
    .paddr   (map_paddr),
    .invalid (map_invalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      port_reg       <= 1'b0;
      we_reg         <= 1'b0;
      p0_ack         <= 1'b0;
      p0_err         <= 1'b0;
      p0_rdata       <= '0;
      p1_ack         <= 1'b0;
      p1_err         <= 1'b0;
      p1_rdata       <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      p0_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_ack <= 1'b0;
      p1_err <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (req_any) begin
            port_reg       <= sel_port;
            last_grant_reg <= sel_port;
            we_reg         <= sel_we;
            if (map_invalid) begin
              state_reg <= RESP_ERR;
            end else begin
              // RAM controls are registered so they are valid for exactly the ISSUE cycle.
              state_reg <= ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= map_paddr;
              mem_wdata <= sel_wdata;
            end
          end
        end

        ISSUE: begin
          state_reg <= WAIT;
        end

        WAIT: begin
          if (port_reg) begin
            p1_ack <= 1'b1;
            if (!we_reg) p1_rdata <= mem_rdata;
          end else begin
            p0_ack <= 1'b1;
            if (!we_reg) p0_rdata <= mem_rdata;
          end
          state_reg <= IDLE;
        end

        RESP_ERR: begin
          if (port_reg) begin
            p1_ack <= 1'b1;
            p1_err <= 1'b1;
          end else begin
            p0_ack <= 1'b1;
            p0_err <= 1'b1;
          end
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural single-port RAM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p0_ack, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p1_ack, p1_err;
  logic [31:0] p1_rdata;
  logic        mem_en, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:2047];
  logic        bd_we = 1'b0;
  logic [10:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
    logic [10:0] maddr;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one request, holds it until ack, then releases it; records what was seen.
  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output bit got_ack, output bit got_err,
                           output logic [31:0] got_rdata, output int lat, output int en_c,
                           output int we_c, output logic [10:0] iss_addr);
    got_ack = 0; got_err = 0; got_rdata = '0; lat = -1; en_c = 0; we_c = 0; iss_addr = '0;
    @(negedge clk);
    if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
    else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_en) begin en_c++; iss_addr = mem_addr; end
      if (mem_we) we_c++;
      if (port ? p1_ack : p0_ack) begin
        got_ack = 1; lat = c;
        got_err   = port ? p1_err : p0_err;
        got_rdata = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    p0_req = 0; p1_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({mem_en, mem_we} !== 2'b00) begin n_bad++;
      $display("FAIL reset_mem_ctl_in_reset got=%b exp=00", {mem_en, mem_we}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({p0_ack, p0_err, p1_ack, p1_err} !== 4'b0000) begin n_bad++;
      $display("FAIL reset_ack_err got=%b exp=0000", {p0_ack, p0_err, p1_ack, p1_err}); end
    n_cmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 45'd0) begin n_bad++;
      $display("FAIL reset_mem_bus got en=%b we=%b addr=%h wdata=%h exp all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    n_cmp++; if ({p0_rdata, p1_rdata} !== 64'd0) begin n_bad++;
      $display("FAIL reset_rdata got p0=%h p1=%h exp 0", p0_rdata, p1_rdata); end
    $display("reset: outputs checked after release");
  endtask

  task automatic test_read();
    exp_t e; bit ack, err; logic [31:0] rd; int lat, en_c, we_c; logic [10:0] ia;
    preload(11'h002, 32'hDEADBEEF);
    sb.push_back('{port: 1'b0, err: 1'b0, rdata: 32'hDEADBEEF, maddr: 11'h002, lat: 3});
    do_access(1'b0, 1'b0, 32'h1001_0008, 32'h0, ack, err, rd, lat, en_c, we_c, ia);
    e = sb.pop_front();
    $display("read p0 @10010008: ack=%0d lat=%0d err=%0d rdata=%h maddr=%h", ack, lat, err, rd, ia);
    n_cmp++; if (!ack || lat != e.lat) begin n_bad++; $display("FAIL read_latency got=%0d exp=%0d", lat, e.lat); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL read_rdata got=%h exp=%h", rd, e.rdata); end
    n_cmp++; if (ia !== e.maddr || en_c != 1 || we_c != 0) begin n_bad++;
      $display("FAIL read_issue got addr=%h en=%0d we=%0d exp addr=%h en=1 we=0", ia, en_c, we_c, e.maddr); end
    n_cmp++; if (err !== e.err) begin n_bad++; $display("FAIL read_err got=%b exp=%b", err, e.err); end
  endtask

  task automatic test_write_read();
    exp_t e; bit ack, err; logic [31:0] rd; int lat, en_c, we_c; logic [10:0] ia;
    sb.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h0, maddr: 11'h400, lat: 3});
    do_access(1'b1, 1'b1, 32'h7FFF_EFFC, 32'h1234_5678, ack, err, rd, lat, en_c, we_c, ia);
    e = sb.pop_front();
    $display("write p1 @7FFFEFFC: ack=%0d lat=%0d err=%0d maddr=%h we_cycles=%0d", ack, lat, err, ia, we_c);
    n_cmp++; if (!ack || lat != e.lat || err !== e.err) begin n_bad++;
      $display("FAIL write_ack got lat=%0d err=%b exp lat=%0d err=0", lat, err, e.lat); end
    n_cmp++; if (ia !== e.maddr || we_c != 1 || en_c != 1) begin n_bad++;
      $display("FAIL write_issue got addr=%h we=%0d en=%0d exp addr=%h we=1 en=1", ia, we_c, en_c, e.maddr); end
    n_cmp++; if (rd !== e.rdata) begin n_bad++; $display("FAIL write_rdata_hold got=%h exp=%h", rd, e.rdata); end
    n_cmp++; if (ram[11'h400] !== 32'h1234_5678) begin n_bad++;
      $display("FAIL write_ram_content got=%h exp=12345678", ram[11'h400]); end
    sb.push_back('{port: 1'b1, err: 1'b0, rdata: 32'h1234_5678, maddr: 11'h400, lat: 3});
    do_access(1'b1, 1'b0, 32'h7FFF_EFFC, 32'h0, ack, err, rd, lat, en_c, we_c, ia);
    e = sb.pop_front();
    $display("read p1 @7FFFEFFC: ack=%0d lat=%0d rdata=%h", ack, lat, rd);
    n_cmp++; if (!ack || lat != e.lat || rd !== e.rdata || we_c != 0) begin n_bad++;
      $display("FAIL readback got lat=%0d rdata=%h we=%0d exp lat=3 rdata=%h we=0", lat, rd, we_c, e.rdata); end
  endtask

  task automatic test_boundaries();
    logic [31:0] addrs [6] = '{32'h1001_0FFC, 32'h1001_1000, 32'h7FFF_FFF8,
                               32'h7FFF_FFFC, 32'h1000_FFFC, 32'h7FFF_EFF8};
    bit          ports [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit          errs  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [10:0] maddr [6] = '{11'h3FF, 11'h000, 11'h7FF, 11'h000, 11'h000, 11'h000};
    logic [31:0] dat   [6] = '{32'hA5A5_03FF, 32'h0, 32'h5A5A_07FF, 32'h0, 32'h0, 32'h0};
    exp_t e; bit ack, err; logic [31:0] rd; int lat, en_c, we_c; logic [10:0] ia;
    preload(11'h3FF, 32'hA5A5_03FF);
    preload(11'h7FF, 32'h5A5A_07FF);
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{port: ports[i], err: errs[i], rdata: dat[i], maddr: maddr[i], lat: errs[i] ? 2 : 3});
      do_access(ports[i], 1'b0, addrs[i], 32'h0, ack, err, rd, lat, en_c, we_c, ia);
      e = sb.pop_front();
      $display("boundary p%0d @%h: ack=%0d lat=%0d err=%0d rdata=%h en_cycles=%0d", e.port, addrs[i], ack, lat, err, rd, en_c);
      n_cmp++; if (!ack || lat != e.lat || err !== e.err) begin n_bad++;
        $display("FAIL boundary_%0d got lat=%0d err=%b exp lat=%0d err=%b", i, lat, err, e.lat, e.err); end
      n_cmp++; if (en_c != (e.err ? 0 : 1) || we_c != 0) begin n_bad++;
        $display("FAIL boundary_mem_%0d got en=%0d we=%0d exp en=%0d we=0", i, en_c, we_c, e.err ? 0 : 1); end
      if (!e.err) begin
        n_cmp++; if (ia !== e.maddr || rd !== e.rdata) begin n_bad++;
          $display("FAIL boundary_data_%0d got addr=%h rdata=%h exp addr=%h rdata=%h", i, ia, rd, e.maddr, e.rdata); end
      end
    end
  endtask

  task automatic test_align();
    exp_t e; bit ack, err; logic [31:0] rd; int lat, en_c, we_c; logic [10:0] ia;
    preload(11'h000, 32'h0BAD_F00D);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    sb.push_back('{port: 1'b0, err: 1'b1, rdata: 32'h0, maddr: 11'h000, lat: 2});
`else
    sb.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0BAD_F00D, maddr: 11'h000, lat: 3});
`endif
    do_access(1'b0, 1'b0, 32'h1001_0002, 32'h0, ack, err, rd, lat, en_c, we_c, ia);
    e = sb.pop_front();
    $display("align p0 @10010002: ack=%0d lat=%0d err=%0d rdata=%h maddr=%h", ack, lat, err, rd, ia);
    n_cmp++; if (!ack || lat != e.lat || err !== e.err) begin n_bad++;
      $display("FAIL align got lat=%0d err=%b exp lat=%0d err=%b", lat, err, e.lat, e.err); end
    if (!e.err) begin
      n_cmp++; if (ia !== e.maddr || rd !== e.rdata) begin n_bad++;
        $display("FAIL align_data got addr=%h rdata=%h exp addr=%h rdata=%h", ia, rd, e.maddr, e.rdata); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int got = 0;
    preload(11'h005, 32'h5555_0005);
    for (int k = 0; k < 3; k++)
      sb.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h5555_0005, maddr: 11'h005, lat: 3 + 4 * k});
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h1001_0014;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (p0_ack) begin
        got++;
        $display("back_to_back p0 ack at cycle %0d rdata=%h", c, p0_rdata);
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL b2b_extra_ack got cycle=%0d exp none", c);
        end else begin
          e = sb.pop_front();
          n_cmp++; if (c != e.lat || p0_rdata !== e.rdata) begin n_bad++;
            $display("FAIL b2b_ack got cycle=%0d rdata=%h exp cycle=%0d rdata=%h", c, p0_rdata, e.lat, e.rdata); end
        end
      end
    end
    p0_req = 0;
    repeat (4) @(negedge clk);
    n_cmp++; if (got != 3) begin n_bad++; $display("FAIL b2b_count got=%0d exp=3", got); end
    sb.delete();
  endtask

  task automatic test_fairness();
    exp_t e; int got = 0;
    preload(11'h004, 32'h4444_0004);
    preload(11'h401, 32'h1111_0401);
    apply_reset();
    for (int k = 0; k < 6; k++)
      sb.push_back('{port: k[0], err: 1'b0, rdata: k[0] ? 32'h1111_0401 : 32'h4444_0004,
                     maddr: k[0] ? 11'h401 : 11'h004, lat: 3 * (k + 1)});
    p0_req = 1; p0_we = 0; p0_addr = 32'h1001_0010;
    p1_req = 1; p1_we = 0; p1_addr = 32'h7FFF_F000;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        got++;
        $display("fairness ack cycle %0d p0=%0d p1=%0d rdata=%h", c, p0_ack, p1_ack, p1_ack ? p1_rdata : p0_rdata);
        if (sb.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL fair_extra_ack got cycle=%0d exp none", c);
        end else begin
          e = sb.pop_front();
          n_cmp++; if (c != e.lat || {p1_ack, p0_ack} !== (e.port ? 2'b10 : 2'b01) ||
                       (e.port ? p1_rdata : p0_rdata) !== e.rdata) begin n_bad++;
            $display("FAIL fair_grant got cycle=%0d acks=%b exp cycle=%0d port=%0d rdata=%h",
                     c, {p1_ack, p0_ack}, e.lat, e.port, e.rdata); end
        end
      end
    end
    p0_req = 0; p1_req = 0;
    repeat (4) @(negedge clk);
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL fair_count got=%0d exp=6", got); end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e; int acks = 0; int lat = -1; int we_c = 0; bit err = 0;
    preload(11'h008, 32'h1111_1111);
    @(negedge clk);
    p0_req = 1; p0_we = 1; p0_addr = 32'h1001_0020; p0_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_cmp++; if ({mem_en, mem_we} !== 2'b11) begin n_bad++;
      $display("FAIL midreset_issue got en/we=%b exp=11", {mem_en, mem_we}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_en, mem_we} !== 2'b00) begin n_bad++;
      $display("FAIL midreset_async_drop got en/we=%b exp=00", {mem_en, mem_we}); end
    repeat (3) begin
      @(negedge clk);
      if (p0_ack || p1_ack) acks++;
    end
    n_cmp++; if (acks != 0 || ram[11'h008] !== 32'h1111_1111) begin n_bad++;
      $display("FAIL midreset_abort got acks=%0d ram=%h exp acks=0 ram=11111111", acks, ram[11'h008]); end
    sb.push_back('{port: 1'b0, err: 1'b0, rdata: 32'h0, maddr: 11'h008, lat: 3});
    rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_we) we_c++;
      if (p0_ack) begin lat = c; err = p0_err; break; end
    end
    p0_req = 0;
    @(negedge clk);
    e = sb.pop_front();
    $display("reset mid-write: resumed ack lat=%0d err=%0d we_cycles=%0d ram[8]=%h", lat, err, we_c, ram[11'h008]);
    n_cmp++; if (lat != e.lat || err !== e.err || we_c != 1) begin n_bad++;
      $display("FAIL midreset_resume got lat=%0d err=%b we=%0d exp lat=3 err=0 we=1", lat, err, we_c); end
    n_cmp++; if (ram[11'h008] !== 32'hCAFE_F00D) begin n_bad++;
      $display("FAIL midreset_ram got=%h exp=cafef00d", ram[11'h008]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read();
    test_boundaries();
    test_align();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
